// File: rtl/result_drain_ctrl.sv
// -----------------------------------------------------------------------------
// result_drain_ctrl
//
// Reader side of the result SRAM. On a host command it reads a contiguous
// range of result words (address wraps modulo 2^ADDRESSSIZE) and streams them
// out on a valid/ready interface through a small output FIFO, so downstream
// backpressure never drops or duplicates a word.
//
// Optional build macro: RESULT_REVERSE_EN
//   defined     - lane order is reversed as words enter the FIFO
//                 (output lane i = SRAM lane MATRIX_SIZE-1-i)
//   not defined - SRAM words pass through unchanged
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   cmd_valid      command request
//   cmd_ready      high only while idle
//   cmd_base_addr  first word address
//   cmd_len        number of words (0 = empty transfer)
//   sram_read_en   read strobe to the result SRAM
//   sram_address   read address (holds its last value when not reading)
//   sram_data_in   SRAM read data, valid one cycle after the strobe
//   m_valid        stream word valid (FIFO not empty)
//   m_ready        downstream accept
//   m_data         stream word (FIFO head)
//   m_last         high with the final word of a command
//   busy           high while reading or draining
//   done           one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module result_drain_ctrl #(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [ADDRESSSIZE-1:0]                 cmd_base_addr,
    input  logic [ADDRESSSIZE-1:0]                 cmd_len,
    output logic                                   sram_read_en,
    output logic [ADDRESSSIZE-1:0]                 sram_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  sram_data_in,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]  m_data,
    output logic                                   m_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int WORDSIZE = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Control state
    state_t                  state_r;
    logic [ADDRESSSIZE-1:0]  addr_r;          // next address to read
    logic [ADDRESSSIZE-1:0]  rem_r;           // reads still to issue
    logic                    sram_read_en_r;
    logic [ADDRESSSIZE-1:0]  sram_address_r;
    logic                    rd_last_r;       // read issued this cycle is the final one
    logic                    inflight_r;      // SRAM data arriving this cycle
    logic                    inflight_last_r; // ... and it is the final word

    // Output FIFO
    logic [WORDSIZE-1:0]     fifo_mem_r  [FIFO_DEPTH];
    logic                    fifo_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [CNT_W-1:0]        count_r;

    // Registered outputs
    logic                    m_valid_r;
    logic [WORDSIZE-1:0]     m_data_r;
    logic                    m_last_r;
    logic                    cmd_ready_r;
    logic                    busy_r;
    logic                    done_r;

    // Next-state helpers
    logic                    cmd_fire_s;
    logic                    pop_s;
    logic                    push_s;
    logic [WORDSIZE-1:0]     push_data_s;
    logic [CNT_W-1:0]        count_after_pop_s;
    logic [CNT_W-1:0]        count_next_s;
    logic [PTR_W-1:0]        rd_ptr_next_s;
    logic [PTR_W-1:0]        wr_ptr_next_s;
    logic [WORDSIZE-1:0]     head_data_next_s;
    logic                    head_last_next_s;
    logic [CNT_W:0]          occupancy_next_s;
    logic                    space_ok_s;

    // Circular pointer increment for a FIFO depth that need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

`ifdef RESULT_REVERSE_EN
    // Undo the write-side lane reversal so lane 0 is matrix column 0
    function automatic logic [WORDSIZE-1:0] reverse_lanes(input logic [WORDSIZE-1:0] word);
        logic [WORDSIZE-1:0] rev;
        rev = word;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            rev[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW] =
                word[(MATRIX_SIZE-1-i)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
        end
        return rev;
    endfunction

    assign push_data_s = reverse_lanes(sram_data_in);
`else
    assign push_data_s = sram_data_in;
`endif

    // FIFO bookkeeping and next head word; a pop and a push in one cycle both apply
    always_comb begin
        cmd_fire_s        = cmd_valid & cmd_ready_r;
        pop_s             = m_valid_r & m_ready;
        push_s            = inflight_r;
        count_after_pop_s = count_r - {{(CNT_W-1){1'b0}}, pop_s};
        count_next_s      = count_after_pop_s + {{(CNT_W-1){1'b0}}, push_s};

        if (pop_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        if (push_s) begin
            wr_ptr_next_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        // When the FIFO would be empty after the pop, an arriving word becomes
        // the head directly; otherwise the head is the stored entry at the new
        // read pointer, which is never the slot being written this cycle.
        if (count_after_pop_s == {CNT_W{1'b0}}) begin
            if (push_s) begin
                head_data_next_s = push_data_s;
                head_last_next_s = inflight_last_r;
            end else begin
                head_data_next_s = m_data_r;
                head_last_next_s = 1'b0;
            end
        end else begin
            head_data_next_s = fifo_mem_r[rd_ptr_next_s];
            head_last_next_s = fifo_last_r[rd_ptr_next_s];
        end

        // A read issued next cycle must fit alongside the stored words and the
        // read issued this cycle (which lands next cycle).
        occupancy_next_s = {1'b0, count_next_s} + {{CNT_W{1'b0}}, sram_read_en_r};
        space_ok_s       = (occupancy_next_s < (CNT_W+1)'(FIFO_DEPTH));
    end

    // FIFO storage write; entries are only visible through count_r, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r]  <= push_data_s;
            fifo_last_r[wr_ptr_r] <= inflight_last_r;
        end
    end

    // Command FSM, read issue, FIFO pointers and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            addr_r          <= {ADDRESSSIZE{1'b0}};
            rem_r           <= {ADDRESSSIZE{1'b0}};
            sram_read_en_r  <= 1'b0;
            sram_address_r  <= {ADDRESSSIZE{1'b0}};
            rd_last_r       <= 1'b0;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            rd_ptr_r        <= {PTR_W{1'b0}};
            wr_ptr_r        <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
            m_valid_r       <= 1'b0;
            m_data_r        <= {WORDSIZE{1'b0}};
            m_last_r        <= 1'b0;
            cmd_ready_r     <= 1'b1;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            rd_ptr_r        <= rd_ptr_next_s;
            wr_ptr_r        <= wr_ptr_next_s;
            count_r         <= count_next_s;
            m_valid_r       <= (count_next_s != {CNT_W{1'b0}});
            m_data_r        <= head_data_next_s;
            m_last_r        <= head_last_next_s;
            inflight_r      <= sram_read_en_r;
            inflight_last_r <= rd_last_r;
            sram_read_en_r  <= 1'b0;
            rd_last_r       <= 1'b0;
            done_r          <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        cmd_ready_r <= 1'b0;
                        if (cmd_len == {ADDRESSSIZE{1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            // The FIFO is empty in idle, so the first read is
                            // issued on the very next cycle.
                            sram_read_en_r <= 1'b1;
                            sram_address_r <= cmd_base_addr;
                            addr_r         <= cmd_base_addr + ADDRESSSIZE'(1);
                            rem_r          <= cmd_len - ADDRESSSIZE'(1);
                            busy_r         <= 1'b1;
                            if (cmd_len == ADDRESSSIZE'(1)) begin
                                rd_last_r <= 1'b1;
                                state_r   <= ST_DRAIN;
                            end else begin
                                state_r   <= ST_READ;
                            end
                        end
                    end else begin
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (space_ok_s) begin
                        sram_read_en_r <= 1'b1;
                        sram_address_r <= addr_r;
                        addr_r         <= addr_r + ADDRESSSIZE'(1);
                        rem_r          <= rem_r - ADDRESSSIZE'(1);
                        if (rem_r == ADDRESSSIZE'(1)) begin
                            rd_last_r <= 1'b1;
                            state_r   <= ST_DRAIN;
                        end else begin
                            state_r   <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_READ;
                    end
                end

                ST_DRAIN: begin
                    if (pop_s && m_last_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end

                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end

                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_r;
    assign sram_read_en = sram_read_en_r;
    assign sram_address = sram_address_r;
    assign m_valid      = m_valid_r;
    assign m_data       = m_data_r;
    assign m_last       = m_last_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_result_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_result_drain_ctrl
//
// Self-checking bench for result_drain_ctrl. A behavioural SRAM answers reads
// one cycle late. Each command is checked against a reference that lists the
// words the command must deliver (SRAM words base..base+len-1, modulo the
// address space, lane-reversed when RESULT_REVERSE_EN is defined) plus timing
// rules: read order, FIFO occupancy bound, stall stability, latency, done.
// -----------------------------------------------------------------------------
module tb_result_drain_ctrl;

    localparam int ADDR_W     = 10;
    localparam int PSB        = 20;
    localparam int LANES      = 8;
    localparam int WORD_W     = PSB * LANES;
    localparam int DEPTH      = 4;
    localparam int SRAM_WORDS = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              sram_read_en;
    logic [ADDR_W-1:0] sram_address;
    logic [WORD_W-1:0] sram_data_in;
    logic              m_valid;
    logic              m_ready;
    logic [WORD_W-1:0] m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    logic [WORD_W-1:0] sram_mem [SRAM_WORDS];

    int total;
    int bad;

    result_drain_ctrl #(
        .ADDRESSSIZE    (ADDR_W),
        .PARTIAL_SUM_BW (PSB),
        .MATRIX_SIZE    (LANES),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .sram_read_en  (sram_read_en),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result SRAM: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (sram_read_en) sram_data_in <= sram_mem[sram_address];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_i(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_w(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [WORD_W-1:0] fill_lanes(input int v);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*PSB +: PSB] = PSB'(v);
        return w;
    endfunction

    // Word the stream must carry for SRAM address addr
    function automatic logic [WORD_W-1:0] model_word(input int addr);
        logic [WORD_W-1:0] w;
        logic [WORD_W-1:0] r;
        w = sram_mem[addr % SRAM_WORDS];
`ifdef RESULT_REVERSE_EN
        for (int i = 0; i < LANES; i++) r[i*PSB +: PSB] = w[(LANES-1-i)*PSB +: PSB];
`else
        r = w;
`endif
        return r;
    endfunction

    // mode 0: always ready; 1: fixed 1,0,0,1,0,1 pattern; 2: random
    function automatic logic pick_ready(input int mode, input int idx);
        logic [5:0] pat;
        pat = 6'b101001;
        if (mode == 0) return 1'b1;
        else if (mode == 1) return pat[idx % 6];
        else return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_reset_vals(input string tag);
        chk_i({tag, "_cmd_ready"},    int'(cmd_ready),    1);
        chk_i({tag, "_sram_read_en"}, int'(sram_read_en), 0);
        chk_i({tag, "_sram_address"}, int'(sram_address), 0);
        chk_i({tag, "_m_valid"},      int'(m_valid),      0);
        chk_w({tag, "_m_data"},       m_data,             {WORD_W{1'b0}});
        chk_i({tag, "_m_last"},       int'(m_last),       0);
        chk_i({tag, "_busy"},         int'(busy),         0);
        chk_i({tag, "_done"},         int'(done),         0);
    endtask

    // Runs one command from idle; called and returns at a falling edge.
    task automatic run_cmd(input int base, input int len, input int mode,
                           output int n_words, output logic [WORD_W-1:0] first_word,
                           output int last_addr);
        logic [WORD_W-1:0] exp_q[$];
        logic [WORD_W-1:0] prev_data;
        logic prev_last;
        bit   prev_stall;
        bit   fin;
        bit   exp_done;
        int   cyc, reads, acc, first_valid, done_cyc, last_hs, budget;

        exp_q = {};
        for (int k = 0; k < len; k++) exp_q.push_back(model_word(base + k));
        n_words = 0; first_word = {WORD_W{1'b0}}; last_addr = -1;
        reads = 0; acc = 0; first_valid = -1; done_cyc = -1; last_hs = -1;
        prev_stall = 1'b0; prev_data = {WORD_W{1'b0}}; prev_last = 1'b0;
        fin = 1'b0; budget = 60 + 20 * len;

        chk_i("cmd_ready_at_start", int'(cmd_ready), 1);
        cmd_valid     = 1'b1;
        cmd_base_addr = ADDR_W'(base);
        cmd_len       = ADDR_W'(len);
        m_ready       = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 1;

        while (!fin && cyc < budget) begin
            if (done_cyc >= 0) begin
                cmd_valid = 1'b0;
                chk_i("post_done_cmd_ready", int'(cmd_ready),    1);
                chk_i("post_done_busy",      int'(busy),         0);
                chk_i("post_done_done",      int'(done),         0);
                chk_i("post_done_m_valid",   int'(m_valid),      0);
                chk_i("post_done_read_en",   int'(sram_read_en), 0);
                fin = 1'b1;
            end else begin
                exp_done = (len == 0) ? (cyc == 1) : (last_hs >= 0 && cyc == last_hs + 1);
                chk_i("cmd_ready_busy", int'(cmd_ready), 0);
                chk_i("done_pulse",     int'(done),      int'(exp_done));
                chk_i("busy_level",     int'(busy),      int'(len != 0 && !exp_done));
                if (sram_read_en) begin
                    chk_i("rd_addr", int'(sram_address), (base + reads) % SRAM_WORDS);
                    chk_i("rd_within_len", int'(reads < len), 1);
                    chk_i("rd_occupancy_below_depth", int'((reads - acc) < DEPTH), 1);
                    if (reads == 0) chk_i("rd_first_latency", cyc, 1);
                    reads++;
                    last_addr = int'(sram_address);
                end
                if (prev_stall) begin
                    chk_w("stall_data_stable", m_data, prev_data);
                    chk_i("stall_last_stable", int'(m_last), int'(prev_last));
                end
                if (m_valid && first_valid < 0) begin
                    first_valid = cyc;
                    chk_i("first_valid_latency", cyc, 3);
                end
                if (acc >= len) chk_i("no_extra_word", int'(m_valid), 0);
                if (exp_done) done_cyc = cyc;

                m_ready = pick_ready(mode, cyc);
                if (mode == 2) begin
                    cmd_valid     = 1'($urandom_range(0, 1));
                    cmd_base_addr = ADDR_W'($urandom);
                    cmd_len       = ADDR_W'($urandom);
                end
                if (m_valid && m_ready && acc < len) begin
                    chk_w("word_data", m_data, exp_q[acc]);
                    chk_i("word_last", int'(m_last), int'(acc == len - 1));
                    if (acc == 0) first_word = m_data;
                    if (acc == len - 1) begin
                        last_hs = cyc;
                        if (mode == 0) chk_i("full_rate_last_cycle", cyc, len + 2);
                    end
                    acc++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        cmd_valid = 1'b0;
        if (!fin) chk_i("cmd_timeout", cyc, -1);
        chk_i("word_count", acc, len);
        n_words = acc;
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_words;
        int exp_first;
        int exp_last_addr;
    } vec_t;

    localparam int NVEC = 8;

    initial begin
        vec_t vecs[NVEC];
        int n_w;
        int la;
        int got;
        int guard;
        int exp0;
        int exp7;
        logic [WORD_W-1:0] fw;
        logic [WORD_W-1:0] rw;

        total = 0; bad = 0;
        vecs[0] = '{base: 5,    len: 4,  mode: 0, exp_words: 4,  exp_first: 5,    exp_last_addr: 8};
        vecs[1] = '{base: 5,    len: 4,  mode: 1, exp_words: 4,  exp_first: 5,    exp_last_addr: 8};
        vecs[2] = '{base: 1022, len: 4,  mode: 0, exp_words: 4,  exp_first: 1022, exp_last_addr: 1};
        vecs[3] = '{base: 0,    len: 0,  mode: 0, exp_words: 0,  exp_first: 0,    exp_last_addr: -1};
        vecs[4] = '{base: 1023, len: 1,  mode: 1, exp_words: 1,  exp_first: 1023, exp_last_addr: 1023};
        vecs[5] = '{base: 100,  len: 9,  mode: 1, exp_words: 9,  exp_first: 100,  exp_last_addr: 108};
        vecs[6] = '{base: 200,  len: 12, mode: 0, exp_words: 12, exp_first: 200,  exp_last_addr: 211};
        vecs[7] = '{base: 1020, len: 8,  mode: 1, exp_words: 8,  exp_first: 1020, exp_last_addr: 3};

        for (int k = 0; k < SRAM_WORDS; k++) sram_mem[k] = fill_lanes(k);

        rst = 1'b1; cmd_valid = 1'b0; cmd_base_addr = '0; cmd_len = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("idle_after_reset");

        // Directed table
        for (int t = 0; t < NVEC; t++) begin
            run_cmd(vecs[t].base, vecs[t].len, vecs[t].mode, n_w, fw, la);
            chk_i($sformatf("vec%0d_words", t), n_w, vecs[t].exp_words);
            if (vecs[t].exp_words > 0)
                chk_i($sformatf("vec%0d_first_lane0", t), int'(fw[PSB-1:0]), vecs[t].exp_first);
            chk_i($sformatf("vec%0d_last_addr", t), la, vecs[t].exp_last_addr);
        end

        // Lane order: SRAM lane j holds j+100
        rw = '0;
        for (int j = 0; j < LANES; j++) rw[j*PSB +: PSB] = PSB'(j + 100);
        sram_mem[50] = rw;
`ifdef RESULT_REVERSE_EN
        exp0 = 107; exp7 = 100;
`else
        exp0 = 100; exp7 = 107;
`endif
        run_cmd(50, 1, 0, n_w, fw, la);
        chk_i("lane_order_lane0", int'(fw[0 +: PSB]), exp0);
        chk_i("lane_order_lane7", int'(fw[7*PSB +: PSB]), exp7);

        // Reset in the middle of a 6-word transfer, after 2 words delivered
        chk_i("rst_seq_cmd_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_base_addr = ADDR_W'(10); cmd_len = ADDR_W'(6); m_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        got = 0; guard = 0;
        while (got < 2 && guard < 20) begin
            if (m_valid && m_ready) begin
                chk_w("rst_seq_pre_word", m_data, model_word(10 + got));
                got++;
            end
            if (got < 2) begin
                @(negedge clk);
                guard++;
            end
        end
        if (guard >= 20) chk_i("rst_seq_pre_timeout", guard, 0);
        @(negedge clk);
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        check_reset_vals("mid_rst");
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_i("after_rst_no_done",    int'(done),         0);
            chk_i("after_rst_no_valid",   int'(m_valid),      0);
            chk_i("after_rst_no_read",    int'(sram_read_en), 0);
            chk_i("after_rst_cmd_ready",  int'(cmd_ready),    1);
        end
        run_cmd(0, 2, 0, n_w, fw, la);
        chk_i("post_rst_cmd_words", n_w, 2);
        chk_i("post_rst_cmd_last_addr", la, 1);

        // Randomized commands over random SRAM contents
        for (int k = 0; k < SRAM_WORDS; k++)
            sram_mem[k] = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int r = 0; r < 30; r++) begin
            int rb;
            int rl;
            int rm;
            rb = int'($urandom_range(0, SRAM_WORDS - 1));
            rl = int'($urandom_range(0, 12));
            rm = int'($urandom_range(0, 2));
            run_cmd(rb, rl, rm, n_w, fw, la);
            if (rl > 0) begin
                chk_w("rand_first_word", fw, model_word(rb));
                chk_i("rand_last_addr", la, (rb + rl - 1) % SRAM_WORDS);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_drain_ctrl.md
Name: result_drain_ctrl

Overview:
- Reader side of the result SRAM, which the systolic datapath fills with skew-corrected, lane-reversed partial-sum rows.
- On a host command, reads a contiguous range of result words and streams them out over a valid/ready interface.
- Carries a small output FIFO so that downstream backpressure never drops or duplicates a word.
- Sits between the result SRAM read port and the host/DMA result path.

Parameters:
ADDRESSSIZE, 10, result SRAM address width
PARTIAL_SUM_BW, 20, bits per result lane
MATRIX_SIZE, 8, lanes per result word; WORDSIZE = PARTIAL_SUM_BW*MATRIX_SIZE (160)
FIFO_DEPTH, 4, output FIFO entries; legal range 3..16

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_base_addr  in  ADDRESSSIZE  first word address
cmd_len  in  ADDRESSSIZE  number of words to read; 0 is legal (empty transfer)
sram_read_en  out  1  read strobe to result SRAM
sram_address  out  ADDRESSSIZE  read address
sram_data_in  in  WORDSIZE  SRAM data_out, valid 1 cycle after address
m_valid  out  1  stream word valid (FIFO not empty)
m_ready  in  1  downstream accept
m_data  out  WORDSIZE  stream word (FIFO head)
m_last  out  1  high with the final word of a command
busy  out  1  high in READ or DRAIN
done  out  1  one-cycle pulse after last word accepted (or after len-0 command)

Behaviour:
- Reset values: cmd_ready=1, sram_read_en=0, sram_address=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. FIFO empty, in-flight flag cleared, state IDLE.
- rst asserted mid-transfer: everything returns to reset values on the next edge. FIFO contents and remaining count are discarded; no done pulse.
- FSM IDLE -> READ: on cmd_valid & cmd_ready with cmd_len != 0. Latch addr = cmd_base_addr and remaining = cmd_len.
- FSM IDLE -> DONE: on a cmd_len == 0 handshake. DONE lasts exactly one cycle: done=1, m_valid stays 0. Then DONE -> IDLE.
- READ:
  - Issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH.
  - A read drives sram_read_en=1 and sram_address=addr.
  - The same edge sets addr <= addr+1 (mod 2^ADDRESSSIZE, wraps silently) and remaining <= remaining-1.
  - READ -> DRAIN when the last read is issued.
- Read data: inflight is a 1-bit register. Data returned 1 cycle after sram_read_en is pushed into the FIFO tail, tagged last when it is the final word of the command.
- DRAIN: no reads. DRAIN -> DONE on the cycle the last-tagged word handshakes (m_valid & m_ready & m_last). DONE -> IDLE.
- Stream rules:
  - m_data and m_last must stay stable while m_valid & !m_ready.
  - A pop on handshake and a push on the same cycle are both honoured; fifo_count is unchanged.
  - Throughput: 1 word/cycle sustained when m_ready is held high.
- Latency, m_ready high: command handshake at edge N, first sram_read_en in cycle N+1, first m_valid in cycle N+3 (one cycle SRAM, one cycle FIFO write). done pulses the cycle after the last handshake.
- FIFO full (fifo_count + inflight == FIFO_DEPTH): reads stall and addr/remaining hold. Overflow is impossible by construction.
- cmd_valid while busy: ignored, since cmd_ready=0. No queuing.
- sram_address holds its last value when not reading.

Optional Feature:
RESULT_REVERSE_EN
- Defined: lane order is reversed as data enters the FIFO. Output lane i (bits i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW) = SRAM lane MATRIX_SIZE-1-i. This undoes the write-side reversal so lane 0 is matrix column 0.
- Not defined: sram_data_in passes through unchanged.
- The feature adds no latency in either case.

Test Plan:
- Preload SRAM word k = k in every lane; cmd base=5, len=4, m_ready=1 -> m_data lanes 5,6,7,8 on 4 consecutive cycles; m_last only on 8; done one cycle after; busy low afterwards.
- Same command with m_ready toggling 1,0,0,1,0,1... -> exactly 4 words, in order, no duplicates; m_data stable while stalled; sram_read_en never issued when count+inflight=FIFO_DEPTH.
- base=1022, len=4 (ADDRESSSIZE=10) -> addresses 1022,1023,0,1 are read in that order.
- cmd len=0 -> cmd_ready low for 1 cycle, done pulses once, m_valid never asserts, no sram_read_en.
- rst asserted for 1 cycle after 2 of 6 words delivered -> all outputs at reset values next cycle; no done; a new command base=0, len=2 then runs correctly.
- With RESULT_REVERSE_EN defined, SRAM lane j = j+100 -> m_data lane 0 = 107, lane 7 = 100; without the macro, lane 0 = 100.
